// File: rtl/seq_mult.sv
// Sequential shift-add multiplier, signed/unsigned, with a start/busy/done handshake.
// Define SEQ_MULT_EARLY_TERM_EN to leave RUN as soon as the remaining multiplier bits are zero.
module seq_mult #(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 sign_a, sign_b;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH-1:0]     mplier_shr;
    logic [2*WIDTH-1:0]   sum;
    logic [2*WIDTH-1:0]   prod;
    logic                 run_last;

    assign sign_a     = signed_mode & A[WIDTH-1];
    assign sign_b     = signed_mode & B[WIDTH-1];
    // |-2^(W-1)| wraps to 2^(W-1), which is the correct unsigned magnitude
    assign abs_a      = sign_a ? -A : A;
    assign abs_b      = sign_b ? -B : B;
    assign mplier_shr = mplier_q >> 1;
    assign sum        = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign prod       = neg_q ? -sum : sum;

`ifdef SEQ_MULT_EARLY_TERM_EN
    assign run_last = (cnt_q == CNT_W'(WIDTH - 1)) || (mplier_shr == '0);
`else
    assign run_last = (cnt_q == CNT_W'(WIDTH - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN:  if (run_last) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (state_q == S_IDLE && start) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, abs_a};
            mplier_d = abs_b;
            cnt_d    = '0;
            neg_d    = sign_a ^ sign_b;
        end else if (state_q == S_RUN) begin
            acc_d    = sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_shr;
            cnt_d    = cnt_q + CNT_W'(1);
            if (run_last) begin
                hi_d = prod[2*WIDTH-1:WIDTH];
                lo_d = prod[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_seq_mult.sv
// Directed bench for seq_mult (WIDTH=16): products, latency, handshake and reset abort.
// Latency is counted in clock edges after the start-sampling edge (16 edges = done in cycle N+17).
module tb_seq_mult;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          signed_mode;
    logic [W-1:0]  A, B;
    logic          busy, done;
    logic [W-1:0]  hi, lo;

    int n_chk = 0;
    int n_fail = 0;

    seq_mult #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .signed_mode(signed_mode), .A(A), .B(B),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected RUN length: full WIDTH, or magnitude bit-length with early exit.
    function automatic int exp_lat(input logic [W-1:0] b, input logic sm);
        int n;
        logic [W-1:0] m;
        m = (sm && b[W-1]) ? -b : b;
        n = W;
`ifdef SEQ_MULT_EARLY_TERM_EN
        n = 1;
        for (int i = 0; i < W; i++)
            if (m[i]) n = i + 1;
`endif
        return n;
    endfunction

    // Entered and left at posedge+1 in an IDLE cycle; operands scrambled after accept.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sm, output logic [2*W-1:0] res,
                          output int lat);
        start = 1'b1; A = a; B = b; signed_mode = sm;
        @(posedge clk); #1;
        start = 1'b0; A = ~a; B = ~b; signed_mode = ~sm;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        res = {hi, lo};
        @(posedge clk); #1;
    endtask

    logic [2*W-1:0] r;
    int             lat;
    int             pulses;
    bit             seen;

    initial begin
        rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hilo", 64'({hi, lo}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(16'hFFFF, 16'hFFFF, 1'b0, r, lat);
        chk("umax_res", 64'(r), 64'hFFFE0001);
        chk("umax_lat", 64'(lat), 64'(exp_lat(16'hFFFF, 1'b0)));
        chk("idle_after", 64'(busy), 64'd0);
        chk("hold_hilo", 64'({hi, lo}), 64'hFFFE0001);

        run_op(16'hFFFD, 16'h0007, 1'b1, r, lat);
        chk("smix_res", 64'(r), 64'hFFFFFFEB);
        chk("smix_lat", 64'(lat), 64'(exp_lat(16'h0007, 1'b1)));
        run_op(16'hFFFD, 16'h0007, 1'b0, r, lat);
        chk("umix_res", 64'(r), 64'h0006FFEB);
        run_op(16'hFFFD, 16'hFFF9, 1'b1, r, lat);
        chk("snn_res", 64'(r), 64'h00000015);
        chk("snn_lat", 64'(lat), 64'(exp_lat(16'hFFF9, 1'b1)));

        run_op(16'h8000, 16'h8000, 1'b1, r, lat);
        chk("sext_res", 64'(r), 64'h40000000);
        chk("sext_lat", 64'(lat), 64'(exp_lat(16'h8000, 1'b1)));
        run_op(16'h8000, 16'h0001, 1'b1, r, lat);
        chk("smin1_res", 64'(r), 64'hFFFF8000);

        run_op(16'h00FF, 16'h0003, 1'b0, r, lat);
        chk("et3_res", 64'(r), 64'h000002FD);
`ifdef SEQ_MULT_EARLY_TERM_EN
        chk("et3_lat", 64'(lat), 64'd2);
`else
        chk("et3_lat", 64'(lat), 64'd16);
`endif
        run_op(16'h00FF, 16'h0000, 1'b0, r, lat);
        chk("et0_res", 64'(r), 64'h00000000);
`ifdef SEQ_MULT_EARLY_TERM_EN
        chk("et0_lat", 64'(lat), 64'd1);
`else
        chk("et0_lat", 64'(lat), 64'd16);
`endif

        // Handshake: start pulses during RUN and in DONE must be ignored.
        start = 1'b1; A = 16'd5; B = 16'h0107; signed_mode = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        pulses = 0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            if (k == 3) begin
                start = 1'b1; A = 16'd9; B = 16'd9;
            end else if (k == 4) begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                lat = k;
                break;
            end
            if (k == 2) chk("hs_busy_run", 64'(busy), 64'd1);
        end
        chk("hs_lat", 64'(lat), 64'(exp_lat(16'h0107, 1'b0)));
        chk("hs_res", 64'({hi, lo}), 64'd1315);
        chk("hs_busy_done", 64'(busy), 64'd1);
        start = 1'b1; A = 16'd11; B = 16'd13;
        @(posedge clk); #1;
        chk("hs_done_pulse", 64'(done), 64'd0);
        chk("hs_done_ign", 64'(busy), 64'd0);
        chk("hs_hold", 64'({hi, lo}), 64'd1315);
        A = 16'd2; B = 16'd3;
        @(posedge clk); #1;
        start = 1'b0; A = 16'd0; B = 16'd0;
        chk("hs_accept", 64'(busy), 64'd1);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                lat = k;
                break;
            end
        end
        chk("hs2_lat", 64'(lat), 64'(exp_lat(16'd3, 1'b0)));
        chk("hs2_res", 64'({hi, lo}), 64'd6);
        chk("hs_pulses", 64'(pulses), 64'd2);
        @(posedge clk); #1;

        // Reset mid-RUN aborts with no done pulse afterwards.
        start = 1'b1; A = 16'h1234; B = 16'h5678; signed_mode = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_hilo", 64'({hi, lo}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        chk("arst_nodone", 64'(seen), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_mult.md
Name: seq_mult

Overview:
Parametrised sequential shift-add multiplier, the successor to the 16x16 combinational array multiplier. It produces a 2*WIDTH-bit product split into hi/lo, in signed or unsigned mode, using one adder instead of WIDTH partial-product rows. A start/busy/done handshake lets the datapath controller issue multiplies and stall on busy. It sits beside the ALU and feeds the HI/LO result registers.

Parameters:
WIDTH, 16, operand width in bits; product is 2*WIDTH; legal range 4..32.
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only in IDLE
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
A  input  WIDTH  multiplicand; sampled with start
B  input  WIDTH  multiplier; sampled with start
busy  output  1  high in RUN and DONE
done  output  1  single-cycle pulse; hi/lo valid from this cycle on
hi  output  WIDTH  product[2*WIDTH-1:WIDTH]
lo  output  WIDTH  product[WIDTH-1:0]

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, hi=0, lo=0; internal acc/mcand/mplier/cnt cleared. Reset mid-operation aborts the multiply; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE: start=1 -> latch operands, go to RUN. start=0 -> stay. hi/lo hold the last result.
- On accept: sign_a = signed_mode & A[WIDTH-1]; sign_b likewise. mcand = |A| zero-extended to 2*WIDTH; mplier = |B| (WIDTH bits); neg = sign_a ^ sign_b; acc=0; cnt=0. Unsigned mode uses A/B as-is with neg=0.
- |x| for x = -2^(WIDTH-1) is 2^(WIDTH-1), which fits WIDTH unsigned bits. No overflow special case.
- RUN, per cycle:
  - if mplier[0], acc += mcand (2*WIDTH-bit add, no carry-out possible);
  - mcand <<= 1; mplier >>= 1; cnt += 1.
  - Exit when cnt reaches WIDTH-1 in this cycle, i.e. exactly WIDTH RUN cycles.
- RUN->DONE edge: {hi,lo} <= neg ? -(acc_next) : acc_next, where acc_next includes the final add; state=DONE.
- DONE: done=1 for exactly one cycle, busy=1; next state IDLE.
- Latency: start sampled at edge N -> done high in cycle N+WIDTH+1; back-to-back throughput one multiply per WIDTH+2 cycles.
- start while busy=1: ignored, with no queueing. start in the DONE cycle: ignored.
- hi/lo change only on the RUN->DONE edge and on reset.
- Operand changes after acceptance have no effect.

Optional Feature:
SEQ_MULT_EARLY_TERM_EN:
- Defined: RUN also exits to DONE after any cycle in which the post-shift mplier == 0. The minimum is 1 RUN cycle, e.g. B=0 gives done at N+2. Result values are identical; only latency shrinks.
- Undefined: fixed WIDTH-cycle RUN as above; the exit comparator is not synthesised.

Test Plan:
1. Reset: assert rst_n=0 mid-RUN (A=16'h1234, B=16'h5678) -> busy=0, done=0, hi=lo=0 immediately; no done pulse after release.
2. Unsigned max: A=B=16'hFFFF, signed_mode=0 -> hi=16'hFFFE, lo=16'h0001; done exactly 17 cycles after start edge.
3. Signed mixed: A=16'hFFFD (-3), B=16'h0007, signed_mode=1 -> {hi,lo}=32'hFFFFFFEB (-21); same A/B with signed_mode=0 -> hi=16'h0006, lo=16'hFFEB.
4. Signed extreme: A=B=16'h8000, signed_mode=1 -> hi=16'h4000, lo=16'h0000; A=16'h8000, B=16'h0001 -> hi=16'hFFFF, lo=16'h8000.
5. Handshake: pulse start again during RUN and in the DONE cycle with different operands -> ignored; a single done pulse occurs; hi/lo hold until next accepted op; start in the cycle after DONE is accepted.
6. With SEQ_MULT_EARLY_TERM_EN: A=16'h00FF, B=16'h0003 -> {hi,lo}=32'h000002FD, done at N+3; B=0 -> zero result, done at N+2. Without the macro, the same results arrive at N+17.
